// File: rtl/counter_seq_pkg.sv
// Shared types and default sizes for the counter command sequencer.
package counter_seq_pkg;

    localparam int SEQ_WIDTH   = 4;
    localparam int SEQ_DEPTH   = 4;
    localparam int SEQ_DWELL_W = 8;
    localparam int SEQ_RC_W    = 4;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        HOLD
    } seq_state_e;

    typedef struct packed {
        logic                   load_en;
        logic [SEQ_WIDTH-1:0]   load;
        logic                   down;
        logic [SEQ_DWELL_W-1:0] dwell;
    } seq_cmd_t;

endpackage

// File: rtl/seq_cmd_fifo.sv
// Synchronous FIFO with fall-through head; occupancy count drives full/empty.
module seq_cmd_fifo
    import counter_seq_pkg::*;
#(
    parameter int DATA_W = $bits(seq_cmd_t),
    parameter int DEPTH  = SEQ_DEPTH
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    // A full FIFO refuses a push even when the same edge pops.
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];

    // NOTE: storage has no reset; only pointers and count define validity,
    // which keeps the array a plain RAM-style register file.
    always_ff @(posedge clk) begin
        if (rstn && w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // NOTE: reset is sampled synchronously and all state uses non-blocking
    // assignments so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/counter_cmd_seq.sv
// Applies queued timed commands to an up/down counter and reports the
// rollovers seen during each command.
module counter_cmd_seq
    import counter_seq_pkg::*;
#(
    parameter int WIDTH   = SEQ_WIDTH,
    parameter int DEPTH   = SEQ_DEPTH,
    parameter int DWELL_W = SEQ_DWELL_W,
    parameter int RC_W    = SEQ_RC_W
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_load_en,
    input  logic [WIDTH-1:0]   cmd_load,
    input  logic               cmd_down,
    input  logic [DWELL_W-1:0] cmd_dwell,
    input  logic               rollover,
    output logic               load_en,
    output logic [WIDTH-1:0]   load,
    output logic               down,
    output logic               busy,
    output logic               done,
    output logic [RC_W-1:0]    done_rolls
);

    typedef struct packed {
        logic               load_en;
        logic [WIDTH-1:0]   load;
        logic               down;
        logic [DWELL_W-1:0] dwell;
    } cmd_t;

    cmd_t             w_in_cmd;
    cmd_t             w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_cmd_end;
    logic             w_start;
    logic [RC_W-1:0]  w_tally_next;

    seq_state_e       r_state;
    logic [DWELL_W-1:0] r_dwell;
    logic [RC_W-1:0]  r_tally;
    logic             r_load_en;
    logic [WIDTH-1:0] r_load;
    logic             r_down;
    logic             r_busy;
    logic             r_done;

    assign w_in_cmd  = '{cmd_load_en, cmd_load, cmd_down, cmd_dwell};
    assign cmd_ready = !w_full;

    seq_cmd_fifo #(
        .DATA_W ($bits(cmd_t)),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (cmd_valid),
        .i_data  (w_in_cmd),
        .i_pop   (w_start),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // A command ends in APPLY when its dwell is zero, otherwise on the
    // HOLD cycle where the remaining dwell reaches one.
    assign w_cmd_end = ((r_state == APPLY) && (r_dwell == '0)) ||
                       ((r_state == HOLD)  && (r_dwell == DWELL_W'(1)));
    assign w_start   = !w_empty && ((r_state == IDLE) || w_cmd_end);

    assign w_tally_next = (rollover && (r_tally != '1)) ? r_tally + RC_W'(1) : r_tally;

    // done is registered; the tally it reports must still include a rollover
    // arriving in the final cycle itself, so that one bit is added here.
    assign done_rolls = r_done ? w_tally_next : '0;
    assign load_en    = r_load_en;
    assign load       = r_load;
    assign down       = r_down;
    assign busy       = r_busy;
    assign done       = r_done;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_dwell   <= '0;
            r_tally   <= '0;
            r_load_en <= 1'b0;
            r_load    <= '0;
            r_down    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_load_en <= 1'b0;
            r_done    <= 1'b0;
            if (w_start) begin
                r_state   <= APPLY;
                r_load_en <= w_head.load_en;
                r_load    <= w_head.load;
                r_down    <= w_head.down;
                r_dwell   <= w_head.dwell;
                r_tally   <= '0;
                r_busy    <= 1'b1;
                r_done    <= (w_head.dwell == '0);
            end else begin
                case (r_state)
                    APPLY, HOLD: begin
                        if (w_cmd_end) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= HOLD;
                            r_tally <= w_tally_next;
                            if (r_state == HOLD) begin
                                r_dwell <= r_dwell - DWELL_W'(1);
                            end
                            // Predict the final cycle so done lines up with it.
                            r_done <= (r_state == APPLY) ? (r_dwell == DWELL_W'(1))
                                                         : (r_dwell == DWELL_W'(2));
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Randomized and directed bench for counter_cmd_seq with a queue-based model.
module tb_counter_cmd_seq;

    localparam int WIDTH   = 4;
    localparam int DEPTH   = 4;
    localparam int DWELL_W = 8;
    localparam int RC_W    = 4;

    logic               clk = 1'b0;
    logic               rstn;
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_load_en;
    logic [WIDTH-1:0]   cmd_load;
    logic               cmd_down;
    logic [DWELL_W-1:0] cmd_dwell;
    logic               rollover;
    logic               load_en;
    logic [WIDTH-1:0]   load;
    logic               down;
    logic               busy;
    logic               done;
    logic [RC_W-1:0]    done_rolls;

    always #5 clk = ~clk;

    counter_cmd_seq #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .DWELL_W(DWELL_W), .RC_W(RC_W)
    ) dut (
        .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_load_en(cmd_load_en), .cmd_load(cmd_load), .cmd_down(cmd_down),
        .cmd_dwell(cmd_dwell), .rollover(rollover), .load_en(load_en),
        .load(load), .down(down), .busy(busy), .done(done), .done_rolls(done_rolls)
    );

    typedef struct {
        bit       le;
        bit [3:0] ld;
        bit       dn;
        bit [7:0] dw;
    } cmd_s;

    // Reference model: pending queue plus the running command's remaining length.
    cmd_s     m_q[$];
    cmd_s     m_cur;
    bit       m_known = 1'b0;
    bit       m_act   = 1'b0;
    bit       m_first = 1'b0;
    int       m_left  = 0;
    int       m_rolls = 0;
    bit [3:0] m_load  = 4'h0;
    bit       m_down  = 1'b0;

    bit [3:0] ctr = 4'h0;
    int       errors = 0;
    int       checks = 0;

    task automatic drive_cmd(input bit v, input bit le, input bit [3:0] ld,
                             input bit dn, input bit [7:0] dw);
        cmd_valid   = v;
        cmd_load_en = le;
        cmd_load    = ld;
        cmd_down    = dn;
        cmd_dwell   = dw;
    endtask

    // One clock: compare against the model mid-cycle, then advance model and counter.
    task automatic tick();
        logic [12:0] exp_v;
        logic [12:0] act_v;
        bit          exp_done;
        int          r;
        bit          pushed;
        bit          b_rst;
        bit          b_roll;
        bit          b_le;
        bit          b_dn;
        bit [3:0]    b_ld;
        cmd_s        c;
        #1;
        if (m_known) begin
            exp_done = m_act && (m_left == 1);
            r = m_rolls + int'(rollover);
            if (r > 15) r = 15;
            exp_v = {(m_q.size() < DEPTH), m_act, (m_act && m_first) ? m_cur.le : 1'b0,
                     m_load, m_down, exp_done, exp_done ? r[3:0] : 4'h0};
            act_v = {cmd_ready, busy, load_en, load, down, done, done_rolls};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL cycle_model t=%0t {ready,busy,load_en,load,down,done,rolls} got=%b expected=%b",
                         $time, act_v, exp_v);
            end
        end
        pushed = rstn && cmd_valid && (m_q.size() < DEPTH);
        c      = '{cmd_load_en, cmd_load, cmd_down, cmd_dwell};
        b_rst  = rstn;
        b_roll = rollover;
        b_le   = load_en;
        b_ld   = load;
        b_dn   = down;
        @(posedge clk);
        if (!b_rst) begin
            m_q.delete();
            m_act = 0; m_first = 0; m_left = 0; m_rolls = 0;
            m_load = 4'h0; m_down = 1'b0; m_known = 1'b1;
        end else if (m_known) begin
            if (m_act) begin
                m_rolls += int'(b_roll);
                if (m_rolls > 15) m_rolls = 15;
            end
            if (m_act && m_left > 1) begin
                m_left--;
                m_first = 0;
            end else if (m_q.size() > 0) begin
                m_cur   = m_q.pop_front();
                m_act   = 1; m_first = 1;
                m_left  = int'(m_cur.dw) + 1;
                m_rolls = 0;
                m_load  = m_cur.ld;
                m_down  = m_cur.dn;
            end else begin
                m_act = 0; m_first = 0;
            end
            if (pushed) m_q.push_back(c);
        end
        if (b_le) ctr = b_ld;
        else      ctr = b_dn ? ctr - 4'h1 : ctr + 4'h1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        rollover = 1'b0;
        drive_cmd(0, 0, 4'h0, 0, 8'h0);
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        logic [12:0] v;
        rstn = 1'b0;
        rollover = 1'b0;
        drive_cmd(0, 0, 4'h0, 0, 8'h0);
        @(negedge clk);
        tick();
        tick();
        rstn = 1'b1;
        #1;
        v = {cmd_ready, busy, load_en, load, down, done, done_rolls};
        checks++;
        if (v !== 13'b1_0_0_0000_0_0_0000) begin
            errors++;
            $display("FAIL reset_state got=%b expected=%b", v, 13'b1_0_0_0000_0_0_0000);
        end
    endtask

    task automatic test_single();
        bit e_le[7] = '{0, 0, 1, 0, 0, 0, 0};
        bit e_dn[7] = '{0, 0, 0, 0, 0, 1, 0};
        bit e_bz[7] = '{0, 0, 1, 1, 1, 1, 0};
        do_reset();
        for (int k = 0; k < 7; k++) begin
            if (k == 0) drive_cmd(1, 1, 4'hA, 0, 8'd3);
            else        drive_cmd(0, 0, 4'h0, 0, 8'd0);
            #1;
            checks++;
            if ({load_en, done, busy} !== {e_le[k], e_dn[k], e_bz[k]} ||
                (e_le[k] && load !== 4'hA) || (e_dn[k] && done_rolls !== 4'h0)) begin
                errors++;
                $display("FAIL single_cmd k=%0d le/done/busy/load/rolls got=%b%b%b/%h/%h expected=%b%b%b/a/0",
                         k, load_en, done, busy, load, done_rolls, e_le[k], e_dn[k], e_bz[k]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 7; k++) begin
            if (k < 3) drive_cmd(1, 1, 4'(k + 1), 0, 8'd0);
            else       drive_cmd(0, 0, 4'h0, 0, 8'd0);
            #1;
            checks++;
            if (k >= 2 && k <= 4) begin
                if ({load_en, done, busy} !== 3'b111 || load !== 4'(k - 1)) begin
                    errors++;
                    $display("FAIL back_to_back k=%0d le/done/busy=%b%b%b load=%h expected 111 load=%h",
                             k, load_en, done, busy, load, 4'(k - 1));
                end
            end else if ({load_en, done, busy} !== 3'b000) begin
                errors++;
                $display("FAIL back_to_back k=%0d le/done/busy=%b%b%b expected 000", k, load_en, done, busy);
            end
            tick();
        end
    endtask

    task automatic test_fifo_full();
        int       waits[6];
        bit [3:0] seen[$];
        bit       acc;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            waits[i] = 0;
            drive_cmd(1, 1, 4'(i + 1), 0, 8'd20);
            acc = 1'b0;
            while (!acc && waits[i] < 100) begin
                #1;
                acc = cmd_ready;
                if (!acc) waits[i]++;
                tick();
                if (load_en) seen.push_back(load);
            end
            if (!acc) begin
                errors++;
                $display("FAIL fifo_full_accept cmd=%0d not accepted within 100 cycles", i);
            end
        end
        drive_cmd(0, 0, 4'h0, 0, 8'd0);
        for (int n = 0; n < 200 && (busy || m_q.size() > 0); n++) begin
            tick();
            if (load_en) seen.push_back(load);
        end
        checks++;
        if (waits[1] + waits[2] + waits[3] + waits[4] != 0 || waits[5] < 15) begin
            errors++;
            $display("FAIL fifo_full_backpressure waits(1..5)=%0d,%0d,%0d,%0d,%0d expected 0,0,0,0,>=15",
                     waits[1], waits[2], waits[3], waits[4], waits[5]);
        end
        checks++;
        if (seen.size() != 6) begin
            errors++;
            $display("FAIL fifo_full_count applied=%0d expected=6", seen.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (seen[i] !== 4'(i + 1)) begin
                    errors++;
                    $display("FAIL fifo_full_order idx=%0d load=%h expected=%h", i, seen[i], 4'(i + 1));
                end
            end
        end
    endtask

    task automatic test_rollover();
        int  n_done = 0;
        int  n = 0;
        bit [3:0] e_rolls[2] = '{4'd2, 4'd3};
        do_reset();
        ctr = 4'h0;
        while (n_done < 2 && n < 100) begin
            if (n == 0 || n == 1) drive_cmd(1, 1, 4'hE, 0, 8'd20);
            else                  drive_cmd(0, 0, 4'h0, 0, 8'd0);
            rollover = down ? (ctr == 4'h0) : (ctr == 4'hF);
            if (n_done == 1 && m_act && m_left == 1) rollover = 1'b1;
            #1;
            if (done) begin
                checks++;
                if (done_rolls !== e_rolls[n_done]) begin
                    errors++;
                    $display("FAIL rollover_tally cmd=%0d got=%0d expected=%0d",
                             n_done, done_rolls, e_rolls[n_done]);
                end
                n_done++;
            end
            tick();
            n++;
        end
        rollover = 1'b0;
        checks++;
        if (n_done != 2) begin
            errors++;
            $display("FAIL rollover_timeout done pulses=%0d expected=2", n_done);
        end
    endtask

    task automatic test_saturation();
        bit seen_done = 1'b0;
        do_reset();
        rollover = 1'b1;
        for (int n = 0; n < 60 && !seen_done; n++) begin
            if (n == 0) drive_cmd(1, 0, 4'h3, 1, 8'd30);
            else        drive_cmd(0, 0, 4'h0, 0, 8'd0);
            #1;
            if (done) begin
                seen_done = 1'b1;
                checks++;
                if (done_rolls !== 4'hF) begin
                    errors++;
                    $display("FAIL saturation got=%h expected=f", done_rolls);
                end
            end
            tick();
        end
        rollover = 1'b0;
        checks++;
        if (!seen_done) begin
            errors++;
            $display("FAIL saturation_timeout no done within 60 cycles");
        end
    endtask

    task automatic test_reset_mid_hold();
        logic [12:0] v;
        int          n = 0;
        int          bad = 0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_cmd(1, 1, 4'(i + 5), 1, 8'd6);
            tick();
        end
        drive_cmd(0, 0, 4'h0, 0, 8'd0);
        while (!(busy && !load_en) && n < 10) begin
            tick();
            n++;
        end
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        #1;
        v = {cmd_ready, busy, load_en, load, down, done, done_rolls};
        checks++;
        if (v !== 13'b1_0_0_0000_0_0_0000) begin
            errors++;
            $display("FAIL reset_mid_hold_state got=%b expected=%b", v, 13'b1_0_0_0000_0_0_0000);
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            if (load_en || busy) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_mid_hold_flush active cycles after reset=%0d expected=0", bad);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            drive_cmd($urandom_range(0, 2) == 0, 1'($urandom), 4'($urandom), 1'($urandom),
                      ($urandom_range(0, 9) == 0) ? 8'($urandom_range(6, 40)) : 8'($urandom_range(0, 4)));
            rollover = 1'($urandom);
            rstn = ($urandom_range(0, 149) != 0);
            tick();
        end
        rstn = 1'b1;
        drive_cmd(0, 0, 4'h0, 0, 8'd0);
        rollover = 1'b0;
        repeat (200) tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fifo_full();
        test_rollover();
        test_saturation();
        test_reset_mid_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
